// File: rtl/iob_uart_pkg.sv
// iob_uart_pkg: shared definitions for the iob_uart_core UART peripheral.
//   - register address map (UART_SOFTRESET .. UART_RXEN)
//   - transmit / receive FSM state encodings
//   - frame geometry (1 start + 8 data + 1 stop = 10 bits)
//   - divisor clamp helper (bit periods shorter than 2 clocks are not usable)
package iob_uart_pkg;

  localparam int UART_SOFTRESET = 0;
  localparam int UART_DIV       = 1;
  localparam int UART_TXDATA    = 2;
  localparam int UART_TXBUSY    = 3;
  localparam int UART_RXDATA    = 4;
  localparam int UART_RXVALID   = 5;
  localparam int UART_TXEN      = 6;
  localparam int UART_RXEN      = 7;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHIGH
  } rx_state_t;

  function automatic logic [15:0] div_clamp(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/iob_uart_if.sv
// iob_uart_if: native CPU bus (valid/address/wdata/wstrb/rdata/ready).
//   master modport: CPU / testbench side, drives the request.
//   slave  modport: peripheral side, returns ready and rdata.
interface iob_uart_if #(
  parameter int ADDR_W  = 3,
  parameter int WDATA_W = 16,
  parameter int DATA_W  = 32
);
  logic               valid;
  logic [ADDR_W-1:0]  address;
  logic [WDATA_W-1:0] wdata;
  logic               wstrb;
  logic [DATA_W-1:0]  rdata;
  logic               ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 8N1 receiver.
// Ports:
//   clk, rst    clock and synchronous active-high reset (includes soft reset)
//   en          receiver enable; dropping it returns the FSM to idle
//   div         clamped bit period in clk cycles (>= 2)
//   rxd         asynchronous serial input
//   rd_clr      RXDATA register read; clears rx_valid unless a byte lands
//   rx_data     last good byte
//   rx_valid    byte available flag
module uart_rx_engine
  import iob_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] div,
  input  logic        rxd,
  input  logic        rd_clr,
  output logic [7:0]  rx_data,
  output logic        rx_valid
);

  logic        sync_p0, sync_p1, rxd_prev;
  rx_state_t   state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_end, bit_end, start_arm;
  logic        sample_bit, store_byte;

  // synchronizer stage 0 -> stage 1; rxd_prev feeds the falling-edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync_p0  <= rxd;
      sync_p1  <= sync_p0;
      rxd_prev <= sync_p1;
    end
  end

  assign half_end  = (cnt >= (div >> 1) - 16'd1);
  assign bit_end   = (cnt >= div - 16'd1);
  assign start_arm = rxd_prev & ~sync_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:     if (start_arm) state_nxt = RX_START;
        // start bit must still be low at mid-bit, otherwise it was a glitch
        RX_START:    if (half_end) state_nxt = sync_p1 ? RX_IDLE : RX_DATA;
        RX_DATA:     if (bit_end && bit_idx == 3'(DATA_BITS - 1)) state_nxt = RX_STOP;
        RX_STOP:     if (bit_end) state_nxt = sync_p1 ? RX_IDLE : RX_WAITHIGH;
        RX_WAITHIGH: if (sync_p1) state_nxt = RX_IDLE;
        default:     state_nxt = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    sample_bit = 1'b0;
    store_byte = 1'b0;
    if (en) begin
      sample_bit = (state == RX_DATA) && bit_end;
      store_byte = (state == RX_STOP) && bit_end && sync_p1;
    end
  end

  // counter restarts on every state change so data samples sit one full
  // bit period apart, starting from the start-bit midpoint
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      cnt <= (state_nxt != state || bit_end) ? 16'd0 : cnt + 16'd1;
      if (state == RX_START)  bit_idx <= '0;
      else if (sample_bit)    bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sample_bit) shift   <= {sync_p1, shift[7:1]};
    if (store_byte) rx_data <= shift;
  end

  // a completed byte beats a coinciding RXDATA read
  always_ff @(posedge clk) begin
    if (rst)             rx_valid <= 1'b0;
    else if (store_byte) rx_valid <= 1'b1;
    else if (rd_clr)     rx_valid <= 1'b0;
  end

endmodule

// File: rtl/iob_uart_core.sv
// iob_uart_core: memory-mapped 8N1 UART with RTS/CTS flow control.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   bus        native CPU bus (slave): one-cycle ready pulse, registered rdata
//   txd        serial output, idles high
//   rxd        serial input (asynchronous)
//   rts        high = receiver can take a byte
//   cts        high = peer can take a byte
// Build option: define UART_HW_FLOWCTL_EN to honour cts and drive rts from
// receiver state; otherwise cts is ignored and rts is tied high.
// Register map: 0 SOFTRESET(W) 1 DIV(W) 2 TXDATA(W) 3 TXBUSY(R)
//               4 RXDATA(R) 5 RXVALID(R) 6 TXEN(W) 7 RXEN(W)
module iob_uart_core
  import iob_uart_pkg::*;
#(
  parameter int          ADDR_W  = 3,
  parameter int          WDATA_W = 16,
  parameter int          DATA_W  = 32,
  parameter logic [15:0] DIV_RST = 16'd0
) (
  input  logic      clk,
  input  logic      rst,
  iob_uart_if.slave bus,
  output logic      txd,
  input  logic      rxd,
  output logic      rts,
  input  logic      cts
);

  logic [ADDR_W-1:0]  addr;
  logic [WDATA_W-1:0] wdata;
  logic               accept, wr, rd;
  logic               soft_rst, eng_rst;
  logic [15:0]        div_q, div_eff;
  logic               txen, rxen;
  logic               cts_eff;
  logic [DATA_W-1:0]  rd_mux;

  logic [7:0]  tx_hold;
  logic        tx_pending, tx_busy, tx_start, tx_bit_end;
  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;

  logic [7:0]  rx_data;
  logic        rx_valid;

  assign addr  = bus.address;
  assign wdata = bus.wdata;

  // the master holds valid until it sees ready, so ignore the held cycle
  assign accept   = bus.valid & ~bus.ready;
  assign wr       = accept & bus.wstrb;
  assign rd       = accept & ~bus.wstrb;
  assign soft_rst = wr && addr == ADDR_W'(UART_SOFTRESET) && wdata[0];
  assign eng_rst  = rst | soft_rst;
  assign div_eff  = div_clamp(div_q);

`ifdef UART_HW_FLOWCTL_EN
  assign cts_eff = cts;
  assign rts     = rxen & ~rx_valid;
`else
  logic unused_cts;
  assign unused_cts = cts;
  assign cts_eff    = 1'b1;
  assign rts        = 1'b1;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_W'(UART_TXBUSY):  rd_mux = DATA_W'(tx_busy);
      ADDR_W'(UART_RXDATA):  rd_mux = DATA_W'(rx_data);
      ADDR_W'(UART_RXVALID): rd_mux = DATA_W'(rx_valid);
      default:               rd_mux = '0;
    endcase
  end

  // bus response: rdata is only non-zero during the ready cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= accept;
      bus.rdata <= rd ? rd_mux : '0;
    end
  end

  // configuration survives soft reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RST;
      txen  <= 1'b0;
      rxen  <= 1'b0;
    end else if (wr) begin
      if (addr == ADDR_W'(UART_DIV))  div_q <= wdata[15:0];
      if (addr == ADDR_W'(UART_TXEN)) txen  <= wdata[0];
      if (addr == ADDR_W'(UART_RXEN)) rxen  <= wdata[0];
    end
  end

  assign tx_busy    = tx_pending | (tx_state != TX_IDLE);
  assign tx_start   = (tx_state == TX_IDLE) & tx_pending & txen & cts_eff;
  assign tx_bit_end = (tx_cnt >= div_eff - 16'd1);

  always_ff @(posedge clk) begin
    if (wr && addr == ADDR_W'(UART_TXDATA) && !tx_busy) tx_hold <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (eng_rst)        tx_pending <= 1'b0;
    else if (tx_start)  tx_pending <= 1'b0;
    else if (wr && addr == ADDR_W'(UART_TXDATA) && !tx_busy) tx_pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (eng_rst) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  // TXEN only gates the start, so a frame in flight always completes
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_start) tx_state_nxt = TX_START;
      TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'(DATA_BITS - 1)) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_hold[tx_idx];
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (eng_rst) begin
      tx_cnt <= '0;
      tx_idx <= '0;
    end else begin
      tx_cnt <= (tx_state_nxt != tx_state || tx_bit_end) ? 16'd0 : tx_cnt + 16'd1;
      if (tx_state == TX_START)                tx_idx <= '0;
      else if (tx_state == TX_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
    end
  end

  uart_rx_engine u_rx (
    .clk      (clk),
    .rst      (eng_rst),
    .en       (rxen),
    .div      (div_eff),
    .rxd      (rxd),
    .rd_clr   (rd && addr == ADDR_W'(UART_RXDATA)),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

endmodule

// File: tb/tb_iob_uart_core.sv
// tb_iob_uart_core: directed bench for iob_uart_core. Read responses are
// checked by a monitor against an expected-value queue filled by the
// stimulus; serial-line levels are checked inline at known cycle offsets.
// Honours UART_HW_FLOWCTL_EN for rts/cts expectations.
module tb_iob_uart_core;
  import iob_uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, rts;
  logic cts = 1'b1;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic rxd;
  logic mon_on = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;
  assign rxd = loop ? txd : rxd_drv;

  iob_uart_if #(.ADDR_W(3), .WDATA_W(16), .DATA_W(32)) bus ();

  iob_uart_core #(.ADDR_W(3), .WDATA_W(16), .DATA_W(32), .DIV_RST(16'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .rxd (rxd),
    .rts (rts),
    .cts (cts)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_rts(input logic en, input logic v);
`ifdef UART_HW_FLOWCTL_EN
    return en & ~v;
`else
    return 1'b1 | (en & ~v);
`endif
  endfunction

  task automatic bus_xfer(input int a, input logic [15:0] d, input logic w);
    bit done;
    done = 0;
    @(posedge clk); #1;
    bus.valid   = 1'b1;
    bus.address = 3'(a);
    bus.wdata   = d;
    bus.wstrb   = w;
    for (int i = 0; i < 4 && !done; i++) begin
      @(posedge clk); #1;
      if (bus.ready) done = 1;
    end
    bus.valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL bus_timeout addr=%0d: ready stayed 0, expected 1", a);
    end
  endtask

  task automatic bus_wr(input int a, input logic [15:0] d);
    bus_xfer(a, d, 1'b1);
  endtask

  task automatic bus_rd(input int a, input logic [31:0] v, input string nm);
    exp_t x;
    x.name = nm;
    x.val  = v;
    exp_q.push_back(x);
    bus_xfer(a, 16'd0, 1'b0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (10) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
  endtask

  // read-response monitor
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.ready && !bus.wstrb) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: rdata %0h with no expected entry", bus.rdata);
        end else begin
          e = exp_q.pop_front();
          chk(e.name, bus.rdata, e.val);
        end
      end else if (!bus.ready) begin
        chk("rdata_idle", bus.rdata, 32'd0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f5a;
    logic [9:0] fff;
    bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_rts", rts, exp_rts(1'b0, 1'b0));
    chk("rst_ready", bus.ready, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    bus_rd(UART_TXBUSY, 0, "txbusy_after_rst");
    bus_rd(UART_RXVALID, 0, "rxvalid_after_rst");
    chk("idle_txd", txd, 1);
    chk("idle_rts", rts, exp_rts(1'b0, 1'b0));

    // transmit 0x5A at DIV=10
    bus_wr(UART_DIV, 16'd10);
    bus_wr(UART_TXEN, 16'd1);
    bus_wr(UART_TXDATA, 16'h005A);
    f5a = {1'b1, 8'h5A, 1'b0};
    fork
      begin
        for (int c = 0; c < 100; c++) begin
          @(posedge clk); #1;
          if (c % 10 == 0 || c % 10 == 9) chk($sformatf("tx5a_c%0d", c), txd, f5a[c / 10]);
        end
      end
      begin
        repeat (99) @(posedge clk);
        bus_rd(UART_TXBUSY, 1, "txbusy_last_stop_cycle");
        bus_rd(UART_TXBUSY, 0, "txbusy_after_frame");
      end
    join

    // loopback 0xA5
    loop = 1'b1;
    bus_wr(UART_RXEN, 16'd1);
    chk("rts_rx_enabled", rts, exp_rts(1'b1, 1'b0));
    bus_wr(UART_TXDATA, 16'h00A5);
    repeat (130) @(posedge clk);
    bus_rd(UART_RXVALID, 1, "rxvalid_a5");
    chk("rts_full", rts, exp_rts(1'b1, 1'b1));
    bus_rd(UART_RXDATA, 32'hA5, "rxdata_a5");
    chk("rts_after_read", rts, exp_rts(1'b1, 1'b0));
    bus_rd(UART_RXVALID, 0, "rxvalid_after_read");
    loop = 1'b0;

    // flow control on the transmit start
`ifdef UART_HW_FLOWCTL_EN
    cts = 1'b0;
    bus_wr(UART_TXDATA, 16'h0011);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (c % 20 == 0) chk($sformatf("cts_hold_c%0d", c), txd, 1);
    end
    bus_rd(UART_TXBUSY, 1, "txbusy_cts_hold");
    cts = 1'b1;
    chk("cts_release_same_cycle", txd, 1);
    @(posedge clk); #1;
    chk("cts_release_start", txd, 0);
`else
    cts = 1'b0;
    bus_wr(UART_TXDATA, 16'h0011);
    @(posedge clk); #1;
    chk("cts_ignored_start", txd, 0);
    cts = 1'b1;
`endif
    repeat (110) @(posedge clk);
    bus_rd(UART_TXBUSY, 0, "txbusy_after_11");

    // framing error, glitch, then good byte
    send_rx(8'h55, 1'b0);
    repeat (30) @(posedge clk);
    bus_rd(UART_RXVALID, 0, "rxvalid_framing_err");
    chk("rts_framing_err", rts, exp_rts(1'b1, 1'b0));
    #1 rxd_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd_drv = 1'b1;
    repeat (30) @(posedge clk);
    bus_rd(UART_RXVALID, 0, "rxvalid_glitch");
    send_rx(8'h3C, 1'b1);
    repeat (30) @(posedge clk);
    bus_rd(UART_RXVALID, 1, "rxvalid_3c");
    bus_rd(UART_RXDATA, 32'h3C, "rxdata_3c");

    // soft reset mid-frame
    bus_wr(UART_TXDATA, 16'h0000);
    repeat (30) @(posedge clk);
    #1;
    chk("tx00_midframe", txd, 0);
    bus_wr(UART_SOFTRESET, 16'd1);
    chk("softrst_txd", txd, 1);
    bus_rd(UART_TXBUSY, 0, "softrst_txbusy");
    bus_wr(UART_TXEN, 16'd1);
    bus_wr(UART_TXDATA, 16'h00FF);
    fff = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      if (c == 0 || c == 9 || c == 10) chk($sformatf("div_kept_c%0d", c), txd, fff[c / 10]);
    end
    repeat (100) @(posedge clk);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_reads: %0d left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_uart_core.md
# iob_uart_core

Memory-mapped 8N1 UART peripheral with RTS/CTS hardware flow control, attached to the native CPU bus (valid/address/wdata/wstrb/rdata/ready). It serves as the console and bootloader link of the SoC: firmware and the host-side tester drive the same register map. The peripheral has a programmable baud divisor, separate TX/RX enables and a soft reset.

## Interface
- `ADDR_W`, 3: register address width.
- `WDATA_W`, 16: write data width; wide enough for the divisor.
- `DATA_W`, 32: read data width.
- `DIV_RST`, 16'd0: divisor value loaded at reset.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  bus request.
- `address`  in  ADDR_W  register select.
- `wdata`  in  WDATA_W  write data.
- `wstrb`  in  1  1 = write, 0 = read.
- `rdata`  out  DATA_W  read data, qualified by `ready`.
- `ready`  out  1  request-complete pulse.
- `txd`  out  1  serial output; idles high.
- `rxd`  in  1  serial input; asynchronous.
- `rts`  out  1  high = receiver can accept a byte.
- `cts`  in  1  high = peer can accept a byte.

## Operation
Register map. W = write-only, R = read-only. Reads of W registers return 0.
- 0 `SOFTRESET` (W): writing 1 acts as `rst` for the TX/RX engines and the flags. It does not clear `DIV`.
- 1 `DIV` (W): bit period in clk cycles. Values below 2 are treated as 2.
- 2 `TXDATA` (W): `wdata[7:0]` loads the TX holding register and sets `tx_pending`. A write while `tx_busy` is set is ignored.
- 3 `TXBUSY` (R): `rdata[0]` = `tx_pending | tx_shifting`.
- 4 `RXDATA` (R): `rdata[7:0]` = last received byte. The read clears `rx_valid`.
- 5 `RXVALID` (R): `rdata[0]` = `rx_valid`.
- 6 `TXEN` (W) and 7 `RXEN` (W): bit 0 enables the transmitter or receiver.

Transmitter:
- Starts a frame when `tx_pending & TXEN & cts` all hold.
- Frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts `DIV` cycles.
- When the frame starts, `tx_pending` clears and `tx_shifting` sets. `tx_shifting` clears after the full stop bit.
- Clearing `TXEN` lets the current frame finish.

Receiver:
- `rxd` passes through a 2-flop synchronizer.
- Active only when `RXEN` = 1.
- A falling edge starts reception. The start bit is rechecked at `DIV/2`; if it is high, the event is a glitch and the receiver returns to idle.
- Data bits and the stop bit are sampled every `DIV` cycles from that midpoint.
- Stop = 1: the byte is stored and `rx_valid` sets.
- Stop = 0 (framing error): the byte is discarded and the receiver waits for `rxd` high before re-arming.
- A new byte arriving while `rx_valid` = 1 overwrites the stored byte; `rx_valid` stays 1.
- `rts` = `RXEN & ~rx_valid`.

States:
- TX: IDLE → START → DATA(8) → STOP → IDLE.
- RX: IDLE → START → DATA(8) → STOP → IDLE, with extra transitions START → IDLE (glitch) and STOP → WAITHIGH → IDLE (framing error).

## Timing
- Every request completes in exactly one cycle: `ready` = 1 in the cycle after `valid` is sampled, for one cycle.
- `rdata` is registered and valid only while `ready` = 1; it is 0 otherwise.
- The master holds `valid`, `address`, `wdata` and `wstrb` until it sees `ready`, then drops `valid`.
- Register writes take effect on the `ready` cycle.
- `TXDATA` write → `txd` falls at the earliest 1 cycle after `ready` if `cts` = 1. While `cts` = 0 the start is delayed indefinitely.
- `rx_valid` sets 1 cycle after the stop-bit sample. The receive-to-`rx_valid` latency includes the 2-cycle synchronizer.
- If a read of `RXDATA` and a new byte completion coincide, the new byte wins and `rx_valid` = 1.
- Reset values: `txd` = 1, `rts` = 0, `ready` = 0, `rdata` = 0, `DIV` = `DIV_RST`, `TXEN` = `RXEN` = 0, all flags 0, both FSMs IDLE.
- `rst` or `SOFTRESET` asserted mid-frame aborts the frame immediately: `txd` returns to 1 the next cycle.

## Configuration
- Macro `UART_HW_FLOWCTL_EN`.
- Defined: `cts` gates the transmit start and `rts` follows the rule above.
- Undefined: `cts` is ignored (treated as 1) and `rts` is driven to constant 1. All other behaviour is identical.

## Structure
- Package `iob_uart_pkg` holds:
  - register address constants `UART_SOFTRESET` through `UART_RXEN`;
  - the TX/RX state enums;
  - the frame length constant (10 bits).
- One sub-module, `uart_rx_engine`: synchronizer, receive FSM and bit counters. The top level holds the register file, the bus logic and the transmitter.

## Test plan
- Reset, then read `TXBUSY` and `RXVALID` → both 0; `txd` = 1 and `rts` = 0 throughout.
- `DIV` = 10, `TXEN` = 1, `cts` = 1, write `TXDATA` = 0x5A → `txd` shows 0,0,1,0,1,1,0,1,0,1, each bit 10 cycles; `TXBUSY` = 1 until the end of the stop bit.
- Loop `txd` to `rxd`, `RXEN` = 1, send 0xA5 → `RXVALID` = 1, `rts` = 0, `RXDATA` = 0xA5; after that read, `RXVALID` = 0 and `rts` = 1.
- Hold `cts` = 0, write `TXDATA` = 0x11 → `txd` stays 1 for 200 cycles; release `cts` → frame starts 1 cycle later.
- Inject a byte with stop bit 0 → `RXVALID` stays 0; a following valid 0x3C is received correctly.
- Write `SOFTRESET` = 1 mid-frame → `txd` = 1 next cycle and `TXBUSY` = 0; `DIV` is kept.
